block_peak_accum: RTL

//  Consumes the registered pixel/timing bundle produced by the input unit buffer and computes, per

---
 rtl/block_peak_accum.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/block_peak_accum.sv
// block_peak_accum: per-zone peak (max RGB) accumulation for one backlight row, shadowed and streamed over valid/ready.
// Ports: iODCK clock, iRST_n async active-low reset; iH_Duty block mask, iPixelData 8x RGB888,
//   iV_Address row index, iV_Duty/iOU_en beat qualifiers, iALG_rst frame start flush,
//   iV_Block_Duty_Count line tag; iBlkReady/oBlkValid handshake, oBlkPeak/oBlkH/oBlkV/oBlkLines/oBlkSum
//   zone result, oOverflow sticky dropped-row flag.
// Optional BLK_SUM_EN: per-zone saturating sum of beat maxima on oBlkSum (tied to 0 otherwise).
module block_peak_accum #(
  parameter int NUM_HBLK = 24,
  parameter int HB_W = 5,
  parameter int SUM_W = 20
) (
  input  logic                iODCK,
  input  logic                iRST_n,
  input  logic [NUM_HBLK-1:0] iH_Duty,
  input  logic [191:0]        iPixelData,
  input  logic [3:0]          iV_Address,
  input  logic                iV_Duty,
  input  logic                iOU_en,
  input  logic                iALG_rst,
  input  logic [6:0]          iV_Block_Duty_Count,
  input  logic                iBlkReady,
  output logic                oBlkValid,
  output logic [7:0]          oBlkPeak,
  output logic [HB_W-1:0]     oBlkH,
  output logic [3:0]          oBlkV,
  output logic [6:0]          oBlkLines,
  output logic [SUM_W-1:0]    oBlkSum,
  output logic                oOverflow
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_d;
  logic [HB_W-1:0] idx, idx_d;
  logic q, close_now, row_open, start, busy, last;
  logic [3:0] cur_v, s1_v, shadow_v;
  logic [6:0] row_lines, s1_lines, shadow_lines;
  logic [7:0] pmax, s1_bmax;
  logic [NUM_HBLK-1:0] s1_mask;
  logic s1_close, s1_clr;
  logic [7:0] acc [NUM_HBLK];
  logic [7:0] acc_nxt [NUM_HBLK];
  logic [7:0] shadow [NUM_HBLK];
  assign q = iOU_en & iV_Duty;
  assign close_now = row_open & ((q & (iV_Address != cur_v)) | iALG_rst);
  assign busy = (state == STREAM) | start;
  assign last = idx == HB_W'(NUM_HBLK - 1);
  always_comb begin
    pmax = '0;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 3; c++)
        pmax = iPixelData[24*p+8*c +: 8] > pmax ? iPixelData[24*p+8*c +: 8] : pmax;
  end
  // S1: beat summary plus the old row's identity, captured before the closing beat retags it
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      s1_bmax <= '0;
      s1_mask <= '0;
      s1_close <= 1'b0;
      s1_clr <= 1'b0;
      s1_v <= '0;
      s1_lines <= '0;
      row_open <= 1'b0;
      cur_v <= '0;
      row_lines <= '0;
    end else begin
      s1_bmax <= pmax;
      s1_mask <= iH_Duty & {NUM_HBLK{q}};
      s1_close <= close_now;
      s1_clr <= close_now | iALG_rst;
      s1_v <= cur_v;
      s1_lines <= row_lines;
      row_open <= q | (row_open & ~iALG_rst);
      if (q) begin
        cur_v <= iV_Address;
        row_lines <= iV_Block_Duty_Count;
      end
    end
  // a clearing beat starts from an empty bank, so the closing beat lands in the new row
  always_comb
    for (int k = 0; k < NUM_HBLK; k++)
      acc_nxt[k] = (s1_mask[k] && s1_bmax > (s1_clr ? 8'd0 : acc[k])) ? s1_bmax : (s1_clr ? 8'd0 : acc[k]);
  // S2: accumulate, and on close snapshot the finished row unless the shadow is still in use
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      for (int k = 0; k < NUM_HBLK; k++) begin
        acc[k] <= '0;
        shadow[k] <= '0;
      end
      shadow_v <= '0;
      shadow_lines <= '0;
      start <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      acc <= acc_nxt;
      start <= s1_close & ~busy;
      if (s1_close & ~busy) begin
        shadow <= acc;
        shadow_v <= s1_v;
        shadow_lines <= s1_lines;
      end
      if (s1_close & busy) oOverflow <= 1'b1;
    end
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
    end
  always_comb begin
    state_d = state;
    idx_d = idx;
    if (state == IDLE && start) begin
      state_d = STREAM;
      idx_d = '0;
    end else if (state == STREAM && iBlkReady) begin
      state_d = last ? IDLE : STREAM;
      idx_d = last ? '0 : idx + 1'b1;
    end
  end
  assign oBlkValid = state == STREAM;
  assign oBlkPeak = oBlkValid ? shadow[idx] : '0;
  assign oBlkH = oBlkValid ? idx : '0;
  assign oBlkV = oBlkValid ? shadow_v : '0;
  assign oBlkLines = oBlkValid ? shadow_lines : '0;
`ifdef BLK_SUM_EN
  logic [SUM_W-1:0] acc_sum [NUM_HBLK];
  logic [SUM_W-1:0] sum_nxt [NUM_HBLK];
  logic [SUM_W-1:0] shadow_sum [NUM_HBLK];
  logic [SUM_W-1:0] sum_base [NUM_HBLK];
  logic [SUM_W:0] sum_wide [NUM_HBLK];
  always_comb
    for (int k = 0; k < NUM_HBLK; k++) begin
      sum_base[k] = s1_clr ? '0 : acc_sum[k];
      sum_wide[k] = {1'b0, sum_base[k]} + (SUM_W+1)'(s1_bmax);
      sum_nxt[k] = !s1_mask[k] ? sum_base[k] : sum_wide[k][SUM_W] ? '1 : sum_wide[k][SUM_W-1:0];
    end
  always_ff @(posedge iODCK or negedge iRST_n)
    if (!iRST_n) begin
      for (int k = 0; k < NUM_HBLK; k++) begin
        acc_sum[k] <= '0;
        shadow_sum[k] <= '0;
      end
    end else begin
      acc_sum <= sum_nxt;
      if (s1_close & ~busy) shadow_sum <= acc_sum;
    end
  assign oBlkSum = oBlkValid ? shadow_sum[idx] : '0;
`else
  assign oBlkSum = '0;
`endif
endmodule
